line_pixel_writer: RTL and testbench

// Consumer end of the bresenham pixel stream: accepts (x,y) pixels via the plot/enable handshake,

---
 rtl/line_gfx_pkg.sv | 23 ++
 rtl/pixel_fifo.sv | 66 ++++++
 rtl/line_pixel_writer.sv | 126 ++++++++++++
 tb/tb_line_pixel_writer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_gfx_pkg.sv
// Shared types for the line drawing datapath: screen geometry,
// buffered pixel layout and the memory writer state encoding.
package line_gfx_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COLOR_W  = 8;
    localparam int X_W      = $clog2(SCREEN_W);
    localparam int Y_W      = $clog2(SCREEN_H);

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE
    } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous pixel buffer with a registered head entry;
// ready_o is registered from next-state occupancy.
module pixel_fifo
    import line_gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  pixel_t din_i,
    input  logic   pop_i,
    output pixel_t dout_o,
    output logic   empty_o,
    output logic   vacant_o,
    output logic   ready_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pixel_t          mem_q [DEPTH];
    pixel_t          out_q;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   mcnt_q, mcnt_d, total_d;
    logic            ov_q, ov_d, ready_q, load;

    // Head register refills from storage whenever it is empty or consumed.
    assign load = (!ov_q || pop_i) && (mcnt_q != '0);

    always_comb begin
        mcnt_d  = mcnt_q + CW'(push_i) - CW'(load);
        ov_d    = load || (ov_q && !pop_i);
        total_d = mcnt_d + CW'(ov_d);
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            mcnt_q  <= '0;
            ov_q    <= 1'b0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (load) begin
                out_q  <= mem_q[rptr_q];
                rptr_q <= rptr_q + PW'(1);
            end
            mcnt_q  <= mcnt_d;
            ov_q    <= ov_d;
            ready_q <= (total_d != CW'(DEPTH));
        end
    end

    assign dout_o   = out_q;
    assign empty_o  = !ov_q;
    assign vacant_o = !ov_q && (mcnt_q == '0);
    assign ready_o  = ready_q;

endmodule

// File: rtl/line_pixel_writer.sv
// Pixel stream sink: clips, buffers, and writes linear framebuffer
// addresses through an Avalon-MM master honouring waitrequest.
module line_pixel_writer #(
    parameter int COORD_W    = 32,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plot,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] color,
    input  logic               line_done,
    output logic               enable,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [COLOR_W-1:0] mem_writedata,
    output logic               mem_write,
    input  logic               mem_waitrequest,
    output logic               idle,
    output logic [31:0]        pix_written,
    output logic [31:0]        pix_clipped
);
    import line_gfx_pkg::*;

    pixel_t             pix_in, pix_out;
    wr_state_t          state_q;
    logic               ready, empty, vacant;
    logic               accept, clip, push, pop;
    logic [ADDR_W-1:0]  lin_addr, addr_q, mem_address_q;
    logic [COLOR_W-1:0] data_q, mem_writedata_q;
    logic               mem_write_q;
    logic [31:0]        written_q, clipped_q;

    // Unsigned compare also rejects negative two's-complement coordinates.
    assign clip   = (x >= COORD_W'(SCREEN_W)) || (y >= COORD_W'(SCREEN_H));
    assign accept = plot && ready;
    assign push   = accept && !clip;

    always_comb begin
        pix_in       = '0;
        pix_in.x     = x[X_W-1:0];
        pix_in.y     = y[Y_W-1:0];
        pix_in.color = color;
    end

    pixel_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push),
        .din_i    (pix_in),
        .pop_i    (pop),
        .dout_o   (pix_out),
        .empty_o  (empty),
        .vacant_o (vacant),
        .ready_o  (ready)
    );

    assign pop = !empty &&
                 ((state_q == IDLE) ||
                  (state_q == WRITE && !mem_waitrequest));

    assign lin_addr = ADDR_W'(pix_out.y) * ADDR_W'(SCREEN_W)
                    + ADDR_W'(pix_out.x);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_write_q     <= 1'b0;
            written_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        addr_q  <= lin_addr;
                        data_q  <= pix_out.color;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    mem_address_q   <= addr_q;
                    mem_writedata_q <= data_q;
                    mem_write_q     <= 1'b1;
                    state_q         <= WRITE;
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        mem_write_q <= 1'b0;
                        written_q   <= written_q + 32'd1;
                        if (pop) begin
                            addr_q  <= lin_addr;
                            data_q  <= pix_out.color;
                            state_q <= CALC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clipped_q <= '0;
        else if (accept && clip) clipped_q <= clipped_q + 32'd1;
    end

    assign enable        = ready;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_write     = mem_write_q;
    assign pix_written   = written_q;
    assign pix_clipped   = clipped_q;
    assign idle = ready && vacant && (state_q == IDLE) && line_done;

endmodule

// File: tb/tb_line_pixel_writer.sv
// Self-checking bench for line_pixel_writer: scenario tasks compare
// captured memory writes against an arithmetic pixel/address model.
module tb_line_pixel_writer;

    localparam int SW    = 640;
    localparam int SH    = 480;
    localparam int DEPTH = 4;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] c;
    } px_t;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        plot = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [7:0]  color = '0;
    logic        line_done = 1'b1;
    logic        mem_waitrequest = 1'b0;
    logic        enable, mem_write, idle;
    logic [18:0] mem_address;
    logic [7:0]  mem_writedata;
    logic [31:0] pix_written, pix_clipped;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          stab_err = 0;
    bit          rand_wr = 1'b0;
    bit          held_prev = 1'b0;
    logic [18:0] held_a;
    logic [7:0]  held_d;
    wr_t         wr_q[$];
    px_t         line_q[$];

    always #5 clk = ~clk;

    line_pixel_writer dut (
        .clk             (clk),
        .reset           (reset),
        .plot            (plot),
        .x               (x),
        .y               (y),
        .color           (color),
        .line_done       (line_done),
        .enable          (enable),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest),
        .idle            (idle),
        .pix_written     (pix_written),
        .pix_clipped     (pix_clipped)
    );

    always @(negedge clk) begin
        if (!reset) begin
            held_prev = 1'b0;
        end else begin
            if (plot && enable) acc_cnt++;
            if (held_prev && (!mem_write || mem_address !== held_a ||
                              mem_writedata !== held_d))
                stab_err++;
            held_prev = mem_write && mem_waitrequest;
            held_a    = mem_address;
            held_d    = mem_writedata;
            if (mem_write && !mem_waitrequest)
                wr_q.push_back('{mem_address, mem_writedata});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_wr) mem_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [18:0] exp_addr(input px_t p);
        return 19'(p.y * SW + p.x);
    endfunction

    function automatic bit on_screen(input px_t p);
        return p.x >= 0 && p.x < SW && p.y >= 0 && p.y < SH;
    endfunction

    task automatic make_line(input int x0, input int y0,
                             input int x1, input int y1);
        int dx, dy, sx, sy, err, e2;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        line_q.delete();
        forever begin
            line_q.push_back('{x0, y0, 8'($urandom)});
            if (x0 == x1 && y0 == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x0 += sx; end
            if (e2 <= dx) begin err += dx; y0 += sy; end
        end
    endtask

    task automatic send_px(input px_t p, input int gap);
        int n;
        plot = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        plot  = 1'b1;
        x     = p.x;
        y     = p.y;
        color = p.c;
        n     = 0;
        @(negedge clk);
        while (!enable && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!enable) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: enable=%0b after %0d cycles, need 1",
                     enable, n);
        end
        @(posedge clk);
        #1;
        plot = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (!idle && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = idle;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b want 0", enable); end
        if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", mem_write); end
        if (mem_address !== 19'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mem_address); end
        if (mem_writedata !== 8'd0) begin errors++; $display("FAIL rst_data: got %0h want 0", mem_writedata); end
        if (idle !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", idle); end
        if (pix_written !== 32'd0) begin errors++; $display("FAIL rst_written: got %0d want 0", pix_written); end
        if (pix_clipped !== 32'd0) begin errors++; $display("FAIL rst_clipped: got %0d want 0", pix_clipped); end
        reset = 1'b1;
        checks++;
        if (enable !== 1'b0) begin errors++; $display("FAIL rst_release_enable: got %b want 0", enable); end
        @(posedge clk);
        #1;
        checks += 2;
        if (enable !== 1'b1) begin errors++; $display("FAIL post_rst_enable: got %b want 1", enable); end
        if (idle !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got %b want 1", idle); end
    endtask

    task automatic test_single();
        int w0;
        bit ok;
        wr_q.delete();
        w0 = int'(pix_written);
        line_done = 1'b0;
        send_px('{10, 2, 8'h3C}, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL latency_early: mem_write=%b at +2, want 0", mem_write); end
        @(posedge clk);
        #1;
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL latency_3: mem_write=%b at +3, want 1", mem_write); end
        line_done = 1'b1;
        wait_drain(ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL single_drain: idle=%b want 1", idle); end
        if (wr_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes want 1", wr_q.size());
        end else begin
            if (wr_q[0].a !== 19'd1290) begin errors++; $display("FAIL single_addr: got %0d want 1290", wr_q[0].a); end
            if (wr_q[0].d !== 8'h3C) begin errors++; $display("FAIL single_data: got %0h want 3c", wr_q[0].d); end
        end
        if (int'(pix_written) - w0 != 1) begin
            errors++;
            $display("FAIL single_written: delta %0d want 1", int'(pix_written) - w0);
        end
    endtask

    task automatic test_line();
        int w0, c0, bad;
        bit ok;
        make_line(120, 70, 0, 10);
        wr_q.delete();
        w0 = int'(pix_written);
        c0 = int'(pix_clipped);
        line_done = 1'b0;
        foreach (line_q[i]) send_px(line_q[i], 0);
        line_done = 1'b1;
        wait_drain(ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL line_drain: idle=%b want 1", idle); end
        if (wr_q.size() != 121) begin errors++; $display("FAIL line_count: got %0d want 121", wr_q.size()); end
        if (int'(pix_clipped) != c0) begin errors++; $display("FAIL line_clipped: got %0d want %0d", pix_clipped, c0); end
        if (int'(pix_written) - w0 != 121) begin errors++; $display("FAIL line_written: delta %0d want 121", int'(pix_written) - w0); end
        bad = 0;
        foreach (line_q[i]) begin
            if (i < wr_q.size()) begin
                checks++;
                if (wr_q[i].a !== exp_addr(line_q[i]) || wr_q[i].d !== line_q[i].c) begin
                    errors++;
                    bad++;
                    if (bad <= 4)
                        $display("FAIL line_write[%0d]: got %0d/%0h want %0d/%0h", i,
                                 wr_q[i].a, wr_q[i].d, exp_addr(line_q[i]), line_q[i].c);
                end
            end
        end
    endtask

    task automatic test_stall();
        px_t exp[$];
        int a0, s0, bad;
        bit ok;
        for (int i = 0; i < 10; i++)
            exp.push_back('{int'($urandom_range(0, SW - 1)),
                            int'($urandom_range(0, SH - 1)), 8'($urandom)});
        wr_q.delete();
        a0 = acc_cnt;
        s0 = stab_err;
        mem_waitrequest = 1'b1;
        line_done = 1'b0;
        fork
            begin
                foreach (exp[i]) send_px(exp[i], 0);
            end
            begin
                repeat (20) @(posedge clk);
                #2;
                checks += 5;
                if (enable !== 1'b0) begin errors++; $display("FAIL stall_enable: got %b want 0", enable); end
                if (acc_cnt - a0 != DEPTH + 1) begin
                    errors++;
                    $display("FAIL stall_accepts: got %0d want %0d", acc_cnt - a0, DEPTH + 1);
                end
                if (wr_q.size() != 0) begin errors++; $display("FAIL stall_writes: got %0d want 0", wr_q.size()); end
                if (mem_write !== 1'b1) begin errors++; $display("FAIL stall_request: mem_write=%b want 1", mem_write); end
                if (mem_address !== exp_addr(exp[0])) begin
                    errors++;
                    $display("FAIL stall_addr: got %0d want %0d", mem_address, exp_addr(exp[0]));
                end
                mem_waitrequest = 1'b0;
            end
        join
        line_done = 1'b1;
        wait_drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL stall_drain: idle=%b want 1", idle); end
        if (wr_q.size() != exp.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", wr_q.size(), exp.size()); end
        if (stab_err != s0) begin errors++; $display("FAIL stall_stable: %0d changes while held, want 0", stab_err - s0); end
        bad = 0;
        foreach (exp[i]) begin
            if (i < wr_q.size()) begin
                checks++;
                if (wr_q[i].a !== exp_addr(exp[i]) || wr_q[i].d !== exp[i].c) begin
                    errors++;
                    bad++;
                    if (bad <= 4)
                        $display("FAIL stall_write[%0d]: got %0d/%0h want %0d/%0h", i,
                                 wr_q[i].a, wr_q[i].d, exp_addr(exp[i]), exp[i].c);
                end
            end
        end
    endtask

    task automatic test_clip();
        px_t pts[4];
        int w0, c0;
        bit ok;
        pts[0] = '{640, 0, 8'h11};
        pts[1] = '{0, 480, 8'h22};
        pts[2] = '{-1, 5, 8'h33};
        pts[3] = '{639, 479, 8'h44};
        wr_q.delete();
        w0 = int'(pix_written);
        c0 = int'(pix_clipped);
        line_done = 1'b0;
        foreach (pts[i]) send_px(pts[i], 1);
        line_done = 1'b1;
        wait_drain(ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL clip_drain: idle=%b want 1", idle); end
        if (int'(pix_clipped) - c0 != 3) begin errors++; $display("FAIL clip_count: delta %0d want 3", int'(pix_clipped) - c0); end
        if (int'(pix_written) - w0 != 1) begin errors++; $display("FAIL clip_written: delta %0d want 1", int'(pix_written) - w0); end
        if (wr_q.size() != 1) begin
            errors++;
            $display("FAIL clip_writes: got %0d want 1", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].a !== 19'd307199 || wr_q[0].d !== 8'h44) begin
                errors++;
                $display("FAIL clip_addr: got %0d/%0h want 307199/44", wr_q[0].a, wr_q[0].d);
            end
        end
    endtask

    task automatic test_random();
        px_t exp[$];
        px_t p;
        int w0, c0, s0, nclip, bad;
        bit ok;
        wr_q.delete();
        w0 = int'(pix_written);
        c0 = int'(pix_clipped);
        s0 = stab_err;
        nclip = 0;
        line_done = 1'b0;
        rand_wr = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            p.x = int'($urandom_range(0, SW + 40)) - 20;
            p.y = int'($urandom_range(0, SH + 40)) - 20;
            p.c = 8'($urandom);
            if (on_screen(p)) exp.push_back(p);
            else nclip++;
            send_px(p, int'($urandom_range(0, 2)));
        end
        rand_wr = 1'b0;
        mem_waitrequest = 1'b0;
        line_done = 1'b1;
        wait_drain(ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL rand_drain: idle=%b want 1", idle); end
        if (int'(pix_clipped) - c0 != nclip) begin
            errors++;
            $display("FAIL rand_clipped: delta %0d want %0d", int'(pix_clipped) - c0, nclip);
        end
        if ((int'(pix_written) - w0) + (int'(pix_clipped) - c0) != 1000) begin
            errors++;
            $display("FAIL rand_accounting: written+clipped %0d want 1000",
                     (int'(pix_written) - w0) + (int'(pix_clipped) - c0));
        end
        if (wr_q.size() != exp.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", wr_q.size(), exp.size()); end
        if (stab_err != s0) begin errors++; $display("FAIL rand_stable: %0d changes while held, want 0", stab_err - s0); end
        bad = 0;
        foreach (exp[i]) begin
            if (i < wr_q.size()) begin
                checks++;
                if (wr_q[i].a !== exp_addr(exp[i]) || wr_q[i].d !== exp[i].c) begin
                    errors++;
                    bad++;
                    if (bad <= 4)
                        $display("FAIL rand_write[%0d]: got %0d/%0h want %0d/%0h", i,
                                 wr_q[i].a, wr_q[i].d, exp_addr(exp[i]), exp[i].c);
                end
            end
        end
    endtask

    task automatic test_reset_midwrite();
        int n;
        mem_waitrequest = 1'b1;
        line_done = 1'b0;
        send_px('{7, 9, 8'h5A}, 0);
        n = 0;
        while (!mem_write && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!(mem_write && mem_waitrequest)) begin
            errors++;
            $display("FAIL midrst_setup: mem_write=%b want 1 before reset", mem_write);
        end
        reset = 1'b0;
        #1;
        checks += 7;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b want 0", mem_write); end
        if (mem_address !== 19'd0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", mem_address); end
        if (mem_writedata !== 8'd0) begin errors++; $display("FAIL midrst_data: got %0h want 0", mem_writedata); end
        if (enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %b want 0", enable); end
        if (idle !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", idle); end
        if (pix_written !== 32'd0) begin errors++; $display("FAIL midrst_written: got %0d want 0", pix_written); end
        if (pix_clipped !== 32'd0) begin errors++; $display("FAIL midrst_clipped: got %0d want 0", pix_clipped); end
        @(posedge clk);
        #1;
        mem_waitrequest = 1'b0;
        line_done = 1'b1;
        wr_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (enable !== 1'b1) begin errors++; $display("FAIL midrst_release: enable=%b want 1", enable); end
        repeat (8) @(posedge clk);
        #1;
        checks += 2;
        if (wr_q.size() != 0) begin errors++; $display("FAIL midrst_lost: got %0d writes want 0", wr_q.size()); end
        if (pix_written !== 32'd0) begin errors++; $display("FAIL midrst_nowrite: written=%0d want 0", pix_written); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_line();
        test_stall();
        test_clip();
        test_random();
        test_reset_midwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
